// File: rtl/argon_dbg_pkg.sv
// -----------------------------------------------------------------------------
// argon_dbg_pkg
//
// Shared constants and types for the Wishbone debug bridge.
//   CMD_WRITE / CMD_READ : command bytes accepted in IDLE
//   RSP_OK / RSP_ERR / RSP_BAD : single-byte responses (write done, bus
//                                timeout, unknown command)
//   dbg_state_t : bridge FSM state, also exported on the debug port
// -----------------------------------------------------------------------------
package argon_dbg_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'
  localparam logic [7:0] RSP_BAD   = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } dbg_state_t;

endpackage

// File: rtl/wishbone_if.sv
// -----------------------------------------------------------------------------
// wishbone_if
//
// Single-beat 32-bit Wishbone bundle.
//   master modport : drives cyc, stb, we, adr, sel, dat_o; samples dat_i, ack
//   slave  modport : the mirror image
// dat_o always flows master -> slave, dat_i slave -> master.
// -----------------------------------------------------------------------------
interface wishbone_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, sel, dat_o,
    input  dat_i, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_o,
    output dat_i, ack
  );

endinterface

// File: rtl/wishbone_debug_bridge.sv
// -----------------------------------------------------------------------------
// wishbone_debug_bridge
//
// Turns a UART byte stream into single-beat Wishbone cycles so a host can poke
// any slave on the crossbar without the CPU.
//
// Frames (multi-byte fields MSB first):
//   'W' a3 a2 a1 a0 d3 d2 d1 d0  -> write, answered with 'K'
//   'R' a3 a2 a1 a0              -> read,  answered with the 4 data bytes
//   any other byte in IDLE       -> answered with '?'
//   no ack within TIMEOUT_CYCLES -> cycle dropped, answered with 'E' only
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   rx_data/rx_valid : received byte + one-cycle strobe (no backpressure)
//   tx_data/tx_valid/tx_ready : response byte stream, valid/ready
//   wishbone    : Wishbone master modport
//   dbg_state   : current FSM state, for observation only
//
// Handshake: a response byte transfers on a rising edge where tx_valid and
// tx_ready are both high; tx_valid/tx_data stay put until then. On the bus,
// cyc/stb stay high until ack is sampled high (one ack per command) or the
// timeout expires. Bytes received in BUS or RESP are ignored.
// -----------------------------------------------------------------------------
module wishbone_debug_bridge
  import argon_dbg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  wishbone_if.master  wishbone,
  output dbg_state_t  dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  // Last counter value before giving up; the BUS state is held for exactly
  // TIMEOUT_CYCLES edges counting from 0.
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  dbg_state_t    state_q;
  logic [1:0]    byte_cnt_q;
  logic          is_write_q;
  logic [31:0]   adr_sh_q;
  logic [31:0]   wdat_sh_q;
  logic [TW-1:0] tout_q;

  // Bus outputs are separate from the shift registers so adr/dat_o only
  // change when a cycle is launched.
  logic          cyc_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   wb_adr_q;
  logic [31:0]   wb_dat_q;

  // Response path: tx_data_q holds the byte on offer, rsp_q the bytes still
  // queued behind it, rsp_left_q counts the byte on offer plus the queue.
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic [23:0]   rsp_q;
  logic [2:0]    rsp_left_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      is_write_q <= 1'b0;
      adr_sh_q   <= 32'd0;
      wdat_sh_q  <= 32'd0;
      tout_q     <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      wb_adr_q   <= 32'd0;
      wb_dat_q   <= 32'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      rsp_q      <= 24'd0;
      rsp_left_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            byte_cnt_q <= 2'd0;
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              is_write_q <= (rx_data == CMD_WRITE);
              state_q    <= ADDR;
            end else begin
              tx_data_q  <= RSP_BAD;
              tx_valid_q <= 1'b1;
              rsp_left_q <= 3'd1;
              state_q    <= RESP;
            end
          end
        end

        ADDR: begin
          if (rx_valid) begin
            adr_sh_q   <= {adr_sh_q[23:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;  // wraps to 0 after the 4th byte
            if (byte_cnt_q == 2'd3) begin
              if (is_write_q) begin
                state_q <= DATA;
              end else begin
                wb_adr_q <= {adr_sh_q[23:0], rx_data};
                we_q     <= 1'b0;
                sel_q    <= 4'hF;
                cyc_q    <= 1'b1;
                tout_q   <= '0;
                state_q  <= BUS;
              end
            end
          end
        end

        DATA: begin
          if (rx_valid) begin
            wdat_sh_q  <= {wdat_sh_q[23:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wb_adr_q <= adr_sh_q;
              wb_dat_q <= {wdat_sh_q[23:0], rx_data};
              we_q     <= 1'b1;
              sel_q    <= 4'hF;
              cyc_q    <= 1'b1;
              tout_q   <= '0;
              state_q  <= BUS;
            end
          end
        end

        BUS: begin
          // ack wins over a timeout expiring on the same edge.
          if (wishbone.ack) begin
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            tx_valid_q <= 1'b1;
            state_q    <= RESP;
            if (is_write_q) begin
              tx_data_q  <= RSP_OK;
              rsp_left_q <= 3'd1;
            end else begin
              tx_data_q  <= wishbone.dat_i[31:24];
              rsp_q      <= wishbone.dat_i[23:0];
              rsp_left_q <= 3'd4;
            end
          end else if (tout_q == TOUT_LAST) begin
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            tx_data_q  <= RSP_ERR;
            tx_valid_q <= 1'b1;
            rsp_left_q <= 3'd1;
            state_q    <= RESP;
          end else begin
            tout_q <= tout_q + TW'(1);
          end
        end

        RESP: begin
          // tx_valid_q is always high in this state.
          if (tx_ready) begin
            if (rsp_left_q == 3'd1) begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              tx_data_q  <= rsp_q[23:16];
              rsp_q      <= {rsp_q[15:0], 8'h00};
              rsp_left_q <= rsp_left_q - 3'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign wishbone.cyc   = cyc_q;
  assign wishbone.stb   = cyc_q;
  assign wishbone.we    = we_q;
  assign wishbone.sel   = sel_q;
  assign wishbone.adr   = wb_adr_q;
  assign wishbone.dat_o = wb_dat_q;

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wishbone_debug_bridge.sv
// -----------------------------------------------------------------------------
// tb_wishbone_debug_bridge
//
// Drives command frames into the bridge, plays a Wishbone slave with a
// configurable number of wait states (or no ack at all), collects response
// bytes, and compares everything against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_wishbone_debug_bridge;
  import argon_dbg_pkg::*;

  localparam int TOUT = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  dbg_state_t dbg_state;

  wishbone_if wb ();

  wishbone_debug_bridge #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .wishbone  (wb),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Counters and the comparison helper
  // ---------------------------------------------------------------------------
  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slave model, response collector and reference memory
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bus_t;

  int          wait_states = 0;
  bit          no_ack      = 1'b0;
  int          w_cnt       = 0;
  int          stb_cycles  = 0;
  bus_t        bus_log[$];
  bus_t        rec;
  logic [31:0] slave_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  logic [7:0]  got_q[$];
  bit          stall_rand   = 1'b0;
  int          hold_low     = 0;
  logic [7:0]  hold_byte    = 8'h00;
  bit          prev_pending = 1'b0;
  logic [7:0]  prev_data    = 8'h00;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      wb.ack       = 1'b0;
      w_cnt        = 0;
      prev_pending = 1'b0;
      tx_ready     = 1'b1;
    end else begin
      // Slave: ack after wait_states extra cycles of stb
      if (wb.stb) stb_cycles++;
      if (wb.cyc && wb.stb && !wb.ack && !no_ack) begin
        if (w_cnt == wait_states) begin
          rec.we  = wb.we;
          rec.adr = wb.adr;
          rec.dat = wb.dat_o;
          rec.sel = wb.sel;
          bus_log.push_back(rec);
          if (wb.we) begin
            slave_mem[wb.adr] = wb.dat_o;
            wb.dat_i = 32'd0;
          end else begin
            wb.dat_i = slave_mem.exists(wb.adr) ? slave_mem[wb.adr] : init_val(wb.adr);
          end
          wb.ack = 1'b1;
          w_cnt  = 0;
        end else begin
          w_cnt++;
        end
      end else if (!wb.cyc) begin
        wb.ack = 1'b0;
        w_cnt  = 0;
      end

      // Response side: a byte refused on the last edge must still be on offer
      if (prev_pending) begin
        check("tx_hold_valid", 32'(tx_valid), 32'd1);
        check("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (hold_low > 0 && tx_valid) begin
        tx_ready = 1'b0;
        hold_low--;
        check("tx_stall_data", 32'(tx_data), 32'(hold_byte));
      end else begin
        tx_ready = stall_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      prev_pending = tx_valid && !tx_ready;
      prev_data    = tx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle_gap(input int gap_max);
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cyc"}, 32'(wb.cyc), 32'd0);
    check({tag, "_stb"}, 32'(wb.stb), 32'd0);
    check({tag, "_we"}, 32'(wb.we), 32'd0);
    check({tag, "_adr"}, wb.adr, 32'd0);
    check({tag, "_dato"}, wb.dat_o, 32'd0);
    check({tag, "_sel"}, 32'(wb.sel), 32'd0);
    check({tag, "_txv"}, 32'(tx_valid), 32'd0);
    check({tag, "_txd"}, 32'(tx_data), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // One complete command: expectations come from the frame rules alone.
  task automatic do_cmd(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                        input int ws, input bit noack, input int gap_max, input int junk,
                        input string tag);
    logic [7:0]  exp_q[$];
    logic [31:0] rv;
    bit          is_bus;
    bit          is_wr;
    int          exp_stb;
    int          exp_log;
    int          cyc_cnt;
    is_wr  = (cmd == 8'h57);
    is_bus = is_wr || (cmd == 8'h52);
    if (!is_bus) begin
      exp_q.push_back(8'h3F);
      exp_stb = 0;
    end else if (noack) begin
      exp_q.push_back(8'h45);
      exp_stb = TOUT;
    end else if (is_wr) begin
      exp_q.push_back(8'h4B);
      exp_stb = ws + 1;
    end else begin
      rv = ref_read(a);
      for (int i = 3; i >= 0; i--) exp_q.push_back(rv[8*i +: 8]);
      exp_stb = ws + 1;
    end
    exp_log = (is_bus && !noack) ? 1 : 0;

    wait_states = ws;
    no_ack      = noack;
    stb_cycles  = 0;
    bus_log.delete();
    got_q.delete();

    send_byte(cmd);
    if (is_bus) begin
      for (int i = 3; i >= 0; i--) begin
        idle_gap(gap_max);
        send_byte(a[8*i +: 8]);
      end
      if (is_wr) begin
        for (int i = 3; i >= 0; i--) begin
          idle_gap(gap_max);
          send_byte(d[8*i +: 8]);
        end
      end
      check({tag, "_cyc_rise"}, 32'(wb.cyc), 32'd1);
      if (ws == 0 && !noack) begin
        check({tag, "_txv_early"}, 32'(tx_valid), 32'd0);
        @(negedge clk);
        check({tag, "_txv_lat2"}, 32'(tx_valid), 32'd1);
        check({tag, "_cyc_fall"}, 32'(wb.cyc), 32'd0);
      end
      for (int j = 0; j < junk; j++) send_byte(8'($urandom_range(0, 255)));
    end

    cyc_cnt = 0;
    while (got_q.size() < exp_q.size() && cyc_cnt < 400) begin
      @(negedge clk);
      cyc_cnt++;
    end
    repeat (3) @(negedge clk);

    check({tag, "_resp_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check({tag, "_stb_cycles"}, 32'(stb_cycles), 32'(exp_stb));
    check({tag, "_acks"}, 32'(bus_log.size()), 32'(exp_log));
    if (exp_log == 1 && bus_log.size() > 0) begin
      check({tag, "_we"}, 32'(bus_log[0].we), 32'(is_wr));
      check({tag, "_adr"}, bus_log[0].adr, a);
      check({tag, "_sel"}, 32'(bus_log[0].sel), 32'hF);
      if (is_wr) check({tag, "_dato"}, bus_log[0].dat, d);
    end
    check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_txv_end"}, 32'(tx_valid), 32'd0);

    if (is_wr && !noack) ref_mem[a] = d;
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  logic [7:0]  r_cmd;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  int          r_kind;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    wb.ack   = 1'b0;
    wb.dat_i = 32'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic write, zero-wait slave
    do_cmd(8'h57, 32'h0001_0010, 32'hDEAD_BEEF, 0, 1'b0, 0, 0, "wr_basic");

    // Read with three wait states
    slave_mem[32'h100] = 32'h1234_5678;
    ref_mem[32'h100]   = 32'h1234_5678;
    do_cmd(8'h52, 32'h0000_0100, 32'd0, 3, 1'b0, 0, 0, "rd_ws3");

    // Slave never acks, then the bridge must recover
    do_cmd(8'h52, 32'h0000_0200, 32'd0, 0, 1'b1, 0, 0, "rd_timeout");
    do_cmd(8'h57, 32'h0000_0200, 32'd0, 0, 1'b1, 0, 0, "wr_timeout");
    do_cmd(8'h57, 32'h0000_0200, 32'hCAFE_F00D, 1, 1'b0, 2, 0, "wr_after_to");
    do_cmd(8'h52, 32'h0000_0200, 32'd0, 2, 1'b0, 2, 0, "rd_after_to");

    // Unknown command bytes
    do_cmd(8'h00, 32'd0, 32'd0, 0, 1'b0, 0, 0, "bad_00");
    do_cmd(8'hFF, 32'd0, 32'd0, 0, 1'b0, 0, 0, "bad_ff");

    // Junk bytes during BUS must not leak into the next frame
    do_cmd(8'h52, 32'h0000_0100, 32'd0, 8, 1'b0, 0, 3, "rd_junk");
    do_cmd(8'h57, 32'h0000_0300, 32'h0BAD_C0DE, 0, 1'b0, 0, 0, "wr_after_junk");
    do_cmd(8'h52, 32'h0000_0300, 32'd0, 0, 1'b0, 0, 0, "rd_after_junk");

    // Transmitter stalls for 10 cycles on the first read byte
    hold_low  = 10;
    hold_byte = 8'h12;
    do_cmd(8'h52, 32'h0000_0100, 32'd0, 1, 1'b0, 0, 0, "rd_stall");
    check("stall_consumed", 32'(hold_low), 32'd0);

    // Reset in the middle of a write data field
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst_data");
    reset = 1'b0;
    @(negedge clk);
    do_cmd(8'h52, 32'h0000_0400, 32'd0, 1, 1'b0, 0, 0, "rd_after_rst_data");

    // Reset while a bus cycle is outstanding
    no_ack = 1'b1;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
    repeat (4) @(negedge clk);
    check("rst_bus_pre_cyc", 32'(wb.cyc), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst_bus");
    reset  = 1'b0;
    no_ack = 1'b0;
    @(negedge clk);
    do_cmd(8'h52, 32'h0000_0500, 32'd0, 0, 1'b0, 0, 0, "rd_after_rst_bus");

    // Random frames against the reference model
    for (int k = 0; k < 40; k++) begin
      r_kind = $urandom_range(0, 19);
      r_adr  = 32'h0000_1000 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) r_adr = r_adr + 32'($urandom_range(1, 3));
      r_dat      = $urandom;
      stall_rand = ($urandom_range(0, 1) == 1);
      if (r_kind < 9)       r_cmd = 8'h57;
      else if (r_kind < 19) r_cmd = 8'h52;
      else begin
        r_cmd = 8'($urandom_range(0, 255));
        if (r_cmd == 8'h57 || r_cmd == 8'h52) r_cmd = 8'h00;
      end
      do_cmd(r_cmd, r_adr, r_dat, $urandom_range(0, 4), ($urandom_range(0, 9) == 0),
             2, 0, $sformatf("rnd%0d", k));
    end
    stall_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
